alu_nibble_sequencer: RTL and testbench

//  Upstream/downstream controller for the 4-bit combinational ALU: runs one wide operation as NIBBLES

---
 rtl/alu_nibble_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs one W-bit operation (W = 4*NIBBLES) as NIBBLES back-to-back passes
// through an external 4-bit combinational ALU. Nibble 0 goes first, and each pass's CarryOUT feeds
// the next pass's CarryIN. The final nibble's CarryOUT and overflow become the wide flags.
// Optional feature macro: ALU_SEQ_ZERO_FLAG_EN adds a registered 'zero' output (result == 0).
//
// Handshake: start is sampled on each rising clk edge. It is accepted only in IDLE or DONE, and
// is ignored (not queued) in RUN. done is a one-cycle pulse in the DONE state, the cycle after
// the result and flags registers update. Holding start high through DONE chains the next operation
// with no idle cycle.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4,
  localparam int W      = 4 * NIBBLES,
  localparam int IDX_W  = $clog2(NIBBLES) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic [2:0]   op_code,
  input  logic         carry_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic         zero,
`endif
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [2:0]   alu_op,
  input  logic [3:0]   alu_y,
  input  logic         alu_cout,
  input  logic         alu_ovf,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic               zero_q, zero_d;
`endif

  // State and datapath registers; reset aborts any operation in flight and clears the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      work_q   <= work_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q   <= zero_d;
`endif
    end
  end

  // Next-state, ALU drive and nibble capture; the ALU inputs are zero outside RUN.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    work_d   = work_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d   = zero_q;
`endif
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    alu_cin  = 1'b0;
    alu_op   = 3'b000;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          op_d    = op_code;
          carry_d = carry_in;
          idx_d   = '0;
          work_d  = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Constant-index slice selection keeps every part-select in range.
        for (int n = 0; n < NIBBLES; n++) begin
          if (idx_q == IDX_W'(n)) begin
            alu_a             = a_q[4*n +: 4];
            alu_b             = b_q[4*n +: 4];
            work_d[4*n +: 4]  = alu_y;
          end
        end
        alu_cin = carry_q;
        alu_op  = op_q;
        carry_d = alu_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          result_d = work_d;
          cout_d   = alu_cout;
          ovf_d    = alu_ovf;
`ifdef ALU_SEQ_ZERO_FLAG_EN
          zero_d   = (work_d == '0);
`endif
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer (NIBBLES=4) with a 4-bit ALU model attached.
// The reference computes whole-word results with plain W-bit arithmetic.
module tb_alu_nibble_sequencer;
  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [2:0]   op_code = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out, overflow, alu_cin, alu_cout, alu_ovf;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_y;
  logic [2:0]   alu_op;
  logic [1:0]   dbg_state;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  alu_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .op_code(op_code),
    .carry_in(carry_in), .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .overflow(overflow),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .zero(zero),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op), .alu_y(alu_y),
    .alu_cout(alu_cout), .alu_ovf(alu_ovf), .dbg_state(dbg_state)
  );

  // 4-bit ALU model: 001 subtract, 010 and, 011 or, 100 xor, everything else add.
  logic [4:0] alu_sum;
  logic [3:0] alu_bb;
  always_comb begin
    alu_bb   = (alu_op == 3'b001) ? ~alu_b : alu_b;
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_bb} + {4'b0, alu_cin};
    alu_y    = alu_sum[3:0];
    alu_cout = alu_sum[4];
    alu_ovf  = (alu_a[3] == alu_bb[3]) && (alu_sum[3] != alu_a[3]);
    case (alu_op)
      3'b010: begin alu_y = alu_a & alu_b; alu_cout = 1'b0; alu_ovf = 1'b0; end
      3'b011: begin alu_y = alu_a | alu_b; alu_cout = 1'b0; alu_ovf = 1'b0; end
      3'b100: begin alu_y = alu_a ^ alu_b; alu_cout = 1'b0; alu_ovf = 1'b0; end
      default: ;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [1:0]   flag_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: {overflow, carry_out, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] op, input logic cin);
    logic [W:0]   s;
    logic [W-1:0] bb;
    logic [W-1:0] r;
    logic         co, ov;
    bb = (op == 3'b001) ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
    r  = s[W-1:0];
    co = s[W];
    ov = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    case (op)
      3'b010: begin r = a & b; co = 1'b0; ov = 1'b0; end
      3'b011: begin r = a | b; co = 1'b0; ov = 1'b0; end
      3'b100: begin r = a ^ b; co = 1'b0; ov = 1'b0; end
      default: ;
    endcase
    return {ov, co, r};
  endfunction

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, input logic cin);
    logic [W+1:0] r;
    r = ref_op(a, b, op, cin);
    exp_q.push_back(r[W-1:0]);
    flag_q.push_back(r[W+1:W]);
  endtask

  task automatic check_completion();
    logic [W-1:0] er;
    logic [1:0]   ef;
    er = exp_q.pop_front();
    ef = flag_q.pop_front();
    check("done", done, 1'b1);
    check("result", result, er);
    check("carry_out", carry_out, ef[0]);
    check("overflow", overflow, ef[1]);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("zero", zero, (er == '0));
`endif
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(output int n);
    @(negedge clk);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- driver ----------------
  // One operation with a single-cycle start; optionally pokes start with other operands in RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic cin, input bit poke);
    int lat;
    int extra;
    push_exp(a, b, op, cin);
    @(negedge clk);
    op_a = a; op_b = b; op_code = op; carry_in = cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (lat <= NIB) begin
        check("busy", busy, 1'b1);
        check("alu_a", alu_a, 4'(a >> (4 * (lat - 1))));
        check("alu_b", alu_b, 4'(b >> (4 * (lat - 1))));
        check("alu_op", alu_op, op);
        if (lat == 1) check("alu_cin0", alu_cin, cin);
      end
      if (poke && lat == 2) begin
        start = 1'b1; op_a = ~a; op_b = ~b; op_code = ~op; carry_in = ~cin;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", lat, NIB + 1);
    check_completion();
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("alu_a_idle", alu_a, 4'h0);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 8; i++) begin
        if (done === 1'b1) extra++;
        @(negedge clk);
      end
      check("single_done", extra, 0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int gap;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_result", result, '0);
    check("rst_cout", carry_out, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_alu", {alu_a, alu_b, alu_cin, alu_op}, '0);
    check("rst_state", dbg_state, 2'd0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check("rst_zero", zero, 1'b0);
`endif
    rst = 1'b0;

    // Directed cases
    run_op(16'h00FF, 16'h0001, 3'b000, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 3'b000, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 3'b000, 1'b0, 1'b0);
    run_op(16'h1234, 16'h1111, 3'b000, 1'b1, 1'b1);

    // start held high across two chained operations
    push_exp(16'hA5A5, 16'h5A5B, 3'b000, 1'b0);
    @(negedge clk);
    op_a = 16'hA5A5; op_b = 16'h5A5B; op_code = 3'b000; carry_in = 1'b0; start = 1'b1;
    wait_done(n);
    check("chain_lat1", n, NIB + 1);
    check_completion();
    push_exp(16'h8000, 16'h8000, 3'b000, 1'b1);
    op_a = 16'h8000; op_b = 16'h8000; carry_in = 1'b1;
    wait_done(n);
    check("chain_lat2", n, NIB + 1);
    check_completion();
    start = 1'b0;
    @(negedge clk);
    check("chain_idle", busy, 1'b0);

    // Asynchronous reset two nibbles into an operation
    @(negedge clk);
    op_a = 16'h4321; op_b = 16'h1111; op_code = 3'b000; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_result", result, '0);
    check("abort_flags", {carry_out, overflow}, 2'b00);
    check("abort_alu", {alu_a, alu_b, alu_cin, alu_op}, '0);
    check("abort_state", dbg_state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) n++;
      @(negedge clk);
    end
    check("abort_no_done", n, 0);
    run_op(16'h4321, 16'h1111, 3'b000, 1'b0, 1'b0);

    // Randomized operations across all op codes
    for (int t = 0; t < 40; t++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      if (t % 8 == 0) rb = ~ra;
      run_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
